// File: rtl/dmem_arbiter_if.sv
// Request/response channel for the data-memory arbiter. One bundle type serves both the
// master ports and the memory-side port; sel is only meaningful toward memory, err only toward masters.
interface dmem_arbiter_if;
  logic        req;
  logic        sel;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  // Requester side: issues the command, receives grant and response.
  modport master (
    output req,
    output sel,
    output addr,
    output we,
    output be,
    output wdata,
    input  gnt,
    input  rvalid,
    input  rdata,
    input  err
  );

  // Responder side: accepts the command, returns grant and response.
  modport slave (
    input  req,
    input  sel,
    input  addr,
    input  we,
    input  be,
    input  wdata,
    output gnt,
    output rvalid,
    output rdata,
    output err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter in front of data memory. Out-of-window accesses are granted
// locally and answered with an error response one cycle later, without touching memory.
module dmem_arbiter #(
  parameter logic [31:0] DMEM_ADDR_LOW  = 32'h0010_0000,
  parameter logic [31:0] DMEM_ADDR_HIGH = 32'h0010_8000
) (
  input  logic           HCLK,
  input  logic           HRESETn,
  dmem_arbiter_if.slave  m0,
  dmem_arbiter_if.slave  m1,
  dmem_arbiter_if.master s
);

  logic        m0_in_range;
  logic        m1_in_range;
  logic        any_req;
  logic        win;
  logic        win_in_range;
  logic        granted;

  logic        last_grant_q, last_grant_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_owner_q, resp_owner_d;
  logic        resp_err_q,   resp_err_d;

  logic        resp_fire;
  logic [31:0] resp_data;

  // Window classification, unsigned compare against [LOW, HIGH).
  assign m0_in_range = (m0.addr >= DMEM_ADDR_LOW) && (m0.addr < DMEM_ADDR_HIGH);
  assign m1_in_range = (m1.addr >= DMEM_ADDR_LOW) && (m1.addr < DMEM_ADDR_HIGH);

  // Winner selection: sole requester wins, contention goes to the master not served last.
  always_comb begin
    any_req = m0.req | m1.req;
    win     = 1'b0;
    unique case ({m1.req, m0.req})
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_grant_q;
      default: win = 1'b0;
    endcase
    win_in_range = win ? m1_in_range : m0_in_range;
    // Nothing is granted while reset is held, whatever the masters do.
    granted      = HRESETn & any_req & (~win_in_range | s.gnt);
  end

  // Memory-side command is a straight copy of the winner's fields.
  always_comb begin
    s.req   = 1'b0;
    s.sel   = 1'b0;
    s.addr  = '0;
    s.we    = 1'b0;
    s.be    = '0;
    s.wdata = '0;
    if (HRESETn && any_req) begin
      s.req = 1'b1;
      s.sel = win_in_range;
      if (win) begin
        s.addr  = m1.addr;
        s.we    = m1.we;
        s.be    = m1.be;
        s.wdata = m1.wdata;
      end else begin
        s.addr  = m0.addr;
        s.we    = m0.we;
        s.be    = m0.be;
        s.wdata = m0.wdata;
      end
    end
  end

  always_comb begin
    m0.gnt = granted & ~win;
    m1.gnt = granted &  win;
  end

  // Response tracking: one outstanding slot, refreshed every cycle so grants can stream.
  always_comb begin
    last_grant_d = last_grant_q;
    resp_owner_d = resp_owner_q;
    resp_err_d   = resp_err_q;
    resp_valid_d = granted;
    if (granted) begin
      last_grant_d = win;
      resp_owner_d = win;
      resp_err_d   = ~win_in_range;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      last_grant_q <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_owner_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      resp_valid_q <= resp_valid_d;
      resp_owner_q <= resp_owner_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Memory rvalid only counts when an in-window response is actually expected.
  always_comb begin
    resp_fire = HRESETn & resp_valid_q & (resp_err_q | s.rvalid);
    resp_data = resp_err_q ? 32'h0000_0000 : s.rdata;
  end

  always_comb begin
    m0.rvalid = resp_fire & ~resp_owner_q;
    m1.rvalid = resp_fire &  resp_owner_q;
    m0.err    = m0.rvalid & resp_err_q;
    m1.err    = m1.rvalid & resp_err_q;
    m0.rdata  = m0.rvalid ? resp_data : 32'h0000_0000;
    m1.rdata  = m1.rvalid ? resp_data : 32'h0000_0000;
  end

  // Bundle members with no role on this side of the arbiter.
  logic unused_if_sigs;
  assign unused_if_sigs = ^{m0.sel, m1.sel, s.err};

  a_gnt_onehot: assert property (@(posedge HCLK) !(m0.gnt && m1.gnt));
  a_rvalid_onehot: assert property (@(posedge HCLK) !(m0.rvalid && m1.rvalid));
  a_gnt_needs_req: assert property (@(posedge HCLK) (!m0.gnt || m0.req) && (!m1.gnt || m1.req));
  a_sel_needs_req: assert property (@(posedge HCLK) !s.sel || s.req);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: random and directed traffic from two masters against a
// memory model; expected grants and responses come from a reference model of the arbitration rules.
module tb_dmem_arbiter;
  localparam logic [31:0] Low  = 32'h0010_0000;
  localparam logic [31:0] High = 32'h0010_8000;

  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  dmem_arbiter_if m0_bus ();
  dmem_arbiter_if m1_bus ();
  dmem_arbiter_if s_bus ();

  dmem_arbiter #(
    .DMEM_ADDR_LOW (Low),
    .DMEM_ADDR_HIGH(High)
  ) dut (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .m0     (m0_bus),
    .m1     (m1_bus),
    .s      (s_bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        owner;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  resp_t       exp_q[$];
  bit          last_served;
  logic [31:0] slv_mem[int unsigned];
  logic [31:0] ref_mem[int unsigned];

  function automatic logic [31:0] init_word(int unsigned idx);
    return (idx * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit in_window(logic [31:0] a);
    return (a >= Low) && (a < High);
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) if (be[b]) res[8*b +: 8] = wd[8*b +: 8];
    return res;
  endfunction

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 7))
      0:       return Low;
      1:       return High - 32'd4;
      2:       return High;
      3:       return Low - 32'd4;
      4:       return 32'hFFFF_FFFC;
      5:       return 32'h0000_0000;
      default: return Low + (32'($urandom_range(0, 31)) << 2);
    endcase
  endfunction

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Memory behind the arbiter: answers accepted in-window commands one cycle later and
  // otherwise toggles rvalid with junk data, which the arbiter has to ignore.
  always @(posedge HCLK) begin
    int unsigned idx;
    logic [31:0] old;
    if (s_bus.req && s_bus.sel && s_bus.gnt) begin
      idx = (s_bus.addr - Low) >> 2;
      old = slv_mem.exists(idx) ? slv_mem[idx] : init_word(idx);
      s_bus.rvalid <= 1'b1;
      s_bus.rdata  <= old;
      if (s_bus.we) slv_mem[idx] = merge(old, s_bus.wdata, s_bus.be);
    end else begin
      s_bus.rvalid <= ($urandom_range(0, 2) == 0);
      s_bus.rdata  <= $urandom;
    end
  end

  // Monitor and reference model, sampled mid-cycle.
  always @(negedge HCLK) begin
    resp_t       e;
    logic [3:0]  exp_rsp;
    logic [63:0] exp_data;
    logic [1:0]  exp_gnt;
    logic [79:0] exp_s;
    bit          w;
    logic [31:0] a;
    bit          inwin;
    int unsigned idx;
    logic [31:0] rd;
    if (!HRESETn) begin
      check("reset_outputs",
            {m0_bus.gnt, m1_bus.gnt, m0_bus.rvalid, m1_bus.rvalid, m0_bus.err, m1_bus.err,
             m0_bus.rdata, m1_bus.rdata}, '0);
      exp_q.delete();
      last_served = 1'b1;
    end else begin
      exp_rsp  = '0;
      exp_data = '0;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.owner) begin
          exp_rsp[1:0]   = {1'b1, e.err};
          exp_data[31:0] = e.rdata;
        end else begin
          exp_rsp[3:2]    = {1'b1, e.err};
          exp_data[63:32] = e.rdata;
        end
      end
      check("rvalid_err", {m0_bus.rvalid, m0_bus.err, m1_bus.rvalid, m1_bus.err}, exp_rsp);
      if (exp_rsp[3] || exp_rsp[1]) check("rdata", {m0_bus.rdata, m1_bus.rdata}, exp_data);

      exp_gnt = 2'b00;
      exp_s   = '0;
      if (m0_bus.req || m1_bus.req) begin
        w     = (m0_bus.req && m1_bus.req) ? !last_served : m1_bus.req;
        a     = w ? m1_bus.addr : m0_bus.addr;
        inwin = in_window(a);
        exp_s = {1'b1, inwin, a, w ? m1_bus.we : m0_bus.we, w ? m1_bus.be : m0_bus.be,
                 w ? m1_bus.wdata : m0_bus.wdata};
        if (!inwin || s_bus.gnt) begin
          exp_gnt     = w ? 2'b10 : 2'b01;
          last_served = w;
          rd          = 32'h0;
          if (inwin) begin
            idx = (a - Low) >> 2;
            rd  = ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx);
            if (w ? m1_bus.we : m0_bus.we)
              ref_mem[idx] = merge(rd, w ? m1_bus.wdata : m0_bus.wdata, w ? m1_bus.be : m0_bus.be);
          end
          exp_q.push_back('{owner: w, err: !inwin, rdata: rd});
        end
      end
      check("gnt", {m1_bus.gnt, m0_bus.gnt}, exp_gnt);
      check("s_cmd", {s_bus.req, s_bus.sel, s_bus.addr, s_bus.we, s_bus.be, s_bus.wdata}, exp_s);
    end
  end

  task automatic step(input bit rstn, input bit r0, input logic [31:0] a0, input bit w0,
                      input bit r1, input logic [31:0] a1, input bit w1, input bit sg);
    @(posedge HCLK);
    #1;
    HRESETn      = rstn;
    m0_bus.req   = r0;
    m0_bus.addr  = a0;
    m0_bus.we    = w0;
    m0_bus.be    = 4'($urandom);
    m0_bus.wdata = $urandom;
    m1_bus.req   = r1;
    m1_bus.addr  = a1;
    m1_bus.we    = w1;
    m1_bus.be    = 4'($urandom);
    m1_bus.wdata = $urandom;
    s_bus.gnt    = sg;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    HRESETn      = 1'b0;
    m0_bus.req   = 1'b0;
    m0_bus.sel   = 1'b0;
    m0_bus.addr  = '0;
    m0_bus.we    = 1'b0;
    m0_bus.be    = '0;
    m0_bus.wdata = '0;
    m1_bus.req   = 1'b0;
    m1_bus.sel   = 1'b0;
    m1_bus.addr  = '0;
    m1_bus.we    = 1'b0;
    m1_bus.be    = '0;
    m1_bus.wdata = '0;
    s_bus.gnt    = 1'b0;
    s_bus.err    = 1'b0;
    last_served  = 1'b1;

    // Reset held while both masters request: everything stays quiet.
    repeat (3) step(1'b0, 1'b1, Low, 1'b0, 1'b1, Low + 32'd4, 1'b1, 1'b1);
    // Single in-window read.
    step(1'b1, 1'b1, 32'h0010_0004, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    idle();
    // Fresh reset, then continuous contention: m0, m1, m0, m1.
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b1, Low + 32'd8, 1'b0, 1'b1, Low + 32'd12, 1'b0, 1'b1);
    idle();
    // Out-of-window write on m1, granted without memory grant.
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0010_8000, 1'b1, 1'b0);
    idle();
    // Back-to-back reads at both window edges.
    step(1'b1, 1'b1, 32'h0010_0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 32'h0010_7FFC, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    idle();
    // Reset right after a grant drops the response; contention afterwards favours m0.
    step(1'b1, 1'b1, Low + 32'd16, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b1, Low, 1'b0, 1'b1, Low + 32'd4, 1'b0, 1'b1);
    idle();

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) != 0),
           ($urandom_range(0, 3) != 0), pick_addr(), 1'($urandom),
           ($urandom_range(0, 3) != 0), pick_addr(), 1'($urandom),
           ($urandom_range(0, 3) != 0));
    end
    idle();
    idle();
    @(posedge HCLK);
    @(negedge HCLK);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
